// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: frame width, divisor floor
// and receiver FSM state encodings.
package uart_rx_ctrl_pkg;

    localparam int UART_DATA_W = 8;
    localparam int MIN_DIV     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; occupancy is tracked by a level counter
// so full/empty never depend on pointer equality.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    localparam int            DEPTH   = 2**AW;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       level_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (level_r == DEPTH_L);
    assign empty     = (level_r == '0);
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: synchronizes rxd, deframes bytes with a runtime bit divisor,
// queues them in a FWFT FIFO and throttles the sender through rts.
module uart_rx_ctrl #(
    parameter int DIV_W      = 16,
    parameter int FIFO_AW    = 4,
    parameter int RTS_MARGIN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   div,
    input  logic               rxd,
    output logic               rts,
    input  logic               rd_en,
    output logic               rd_valid,
    output logic [7:0]         rd_data,
    output logic [FIFO_AW:0]   level,
    input  logic               err_clr,
    output logic               frame_err,
    output logic               overrun
);
    import uart_rx_ctrl_pkg::*;

    localparam logic [FIFO_AW:0] DEPTH_L   = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [FIFO_AW:0] MARGIN_L  = (FIFO_AW+1)'(RTS_MARGIN);
    localparam logic [DIV_W-1:0] MIN_DIV_L = DIV_W'(MIN_DIV);

    logic [1:0]             sync_r;
    logic [1:0]             settle_r;
    logic                   armed_r;
    rx_state_t              state_r, state_next_s;
    logic [DIV_W-1:0]       cnt_r, cnt_next_s;
    logic [2:0]             bit_r, bit_next_s;
    logic [UART_DATA_W-1:0] shift_r, shift_next_s;
    logic                   rxs_s, settled_s, cnt_exp_s;
    logic [DIV_W-1:0]       div_eff_s, div_half_s;
    logic                   byte_done_s, frame_set_s, ovr_set_s;
    logic                   fifo_full_s, fifo_empty_s, push_ok_s, pop_ok_s;
    logic [FIFO_AW:0]       level_next_s;
    logic                   rts_r, frame_err_r, overrun_r;

    assign rxs_s      = sync_r[1];
    assign settled_s  = (settle_r == 2'd2);
    assign div_eff_s  = (div < MIN_DIV_L) ? MIN_DIV_L : div;
    assign div_half_s = div_eff_s >> 1;
    assign cnt_exp_s  = (cnt_r <= DIV_W'(1));

    // Two-stage synchronizer plus post-reset settling; armed only once rxs has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 2'b11;
            settle_r <= 2'd0;
            armed_r  <= 1'b0;
        end else begin
            sync_r   <= {sync_r[0], rxd};
            settle_r <= settled_s ? settle_r : settle_r + 2'd1;
            armed_r  <= armed_r | (settled_s & rxs_s);
        end
    end

    // Deframing FSM state, counters and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
        end
    end

    // Next-state and sampling decisions.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = (cnt_r == '0) ? cnt_r : cnt_r - DIV_W'(1);
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        byte_done_s  = 1'b0;
        frame_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A line already low when leaving reset is a frame we joined late.
                if (settled_s && !rxs_s) begin
                    if (armed_r) begin
                        state_next_s = ST_START;
                        cnt_next_s   = div_half_s;
                    end else begin
                        state_next_s = ST_BREAK;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_exp_s) begin
                    if (rxs_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DATA;
                        cnt_next_s   = div_eff_s;
                        bit_next_s   = 3'd0;
                    end
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_exp_s) begin
                    shift_next_s = {rxs_s, shift_r[UART_DATA_W-1:1]};
                    cnt_next_s   = div_eff_s;
                    if (bit_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_next_s = bit_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_exp_s) begin
                    if (rxs_s) begin
                        byte_done_s  = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        frame_set_s  = 1'b1;
                        state_next_s = ST_BREAK;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rxs_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    uart_rx_fifo #(
        .DATA_W (UART_DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (byte_done_s),
        .pop   (rd_en),
        .wdata (shift_r),
        .rdata (rd_data),
        .level (level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign pop_ok_s  = rd_en & ~fifo_empty_s;
    assign push_ok_s = byte_done_s & (~fifo_full_s | pop_ok_s);
    assign ovr_set_s = byte_done_s & ~push_ok_s;

    // Occupancy after this edge, so rts moves in the same cycle as level.
    always_comb begin
        level_next_s = level;
        if (push_ok_s && !pop_ok_s) begin
            level_next_s = level + (FIFO_AW+1)'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            level_next_s = level - (FIFO_AW+1)'(1);
        end else begin
            level_next_s = level;
        end
    end

    // Flow control and sticky error flags; a clear wins over a simultaneous set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_r       <= 1'b1;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            rts_r       <= (DEPTH_L - level_next_s) > MARGIN_L;
            frame_err_r <= err_clr ? 1'b0 : (frame_err_r | frame_set_s);
            overrun_r   <= err_clr ? 1'b0 : (overrun_r | ovr_set_s);
        end
    end

    assign rts       = rts_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign rd_valid  = ~fifo_empty_s;

endmodule
